mem_stage_access: RTL and testbench
===================================

Name: mem_stage_access

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs, covering both the datapath fields and the control fields.
- Converts the registered load/store control into a request/acknowledge transaction on the data-memory port.
- Stalls the front of the pipeline while a memory access is outstanding.
- Drives the registered MEM/WB fields for the write-back stage.

Parameters:
- MAX_WAIT, 16: WAIT-state cycles without dmem_ack before the access is aborted. Legal range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- pc_4  in  32  PC+4 from EX/MEM
- alu_res  in  32  ALU result from EX/MEM; byte address for loads and stores
- wdata  in  32  store data from EX/MEM
- dst  in  5  destination register from EX/MEM
- mem_read  in  1  load request from EX/MEM control
- mem_write  in  1  store request from EX/MEM control
- mem_to_reg  in  2  write-back select from EX/MEM control
- reg_write  in  1  register write enable from EX/MEM control
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = store, 0 = load; registered
- dmem_addr  out  32  word-aligned address, registered
- dmem_wdata  out  32  store data, registered
- dmem_ack  in  1  memory completion, sampled at posedge
- dmem_rdata  in  32  load data, valid when dmem_ack = 1
- stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM while high
- wb_pc_4  out  32  MEM/WB PC+4
- wb_alu_res  out  32  MEM/WB ALU result
- wb_rdata  out  32  MEM/WB load data
- wb_dst  out  5  MEM/WB destination register
- wb_mem_to_reg  out  2  MEM/WB write-back select
- wb_reg_write  out  1  MEM/WB register write enable
- misalign_err  out  1  one-cycle pulse, registered
- timeout_err  out  1  one-cycle pulse, registered

Behaviour:
- Reset: asynchronous, rst = 0.
  - All outputs go to 0, state = IDLE, wait counter = 0.
  - Reset asserted during WAIT drops dmem_req immediately, with no clock edge required.
- States: IDLE, WAIT.
- Definitions used below:
  - mem_op = mem_read | mem_write
  - aligned = (alu_res[1:0] == 2'b00)
  - If mem_read and mem_write are both 1, the access is treated as a store and mem_read is ignored.
- IDLE, mem_op = 0:
  - stall = 0.
  - At posedge, load all wb_* fields from the inputs. wb_rdata = 0.
  - Latency is 1 cycle.
- IDLE, mem_op = 1, not aligned:
  - stall = 0; no memory request is issued.
  - At posedge: misalign_err = 1 for one cycle, wb_reg_write = 0 (bubble), remaining wb_* fields loaded as above.
- IDLE, mem_op = 1, aligned:
  - stall = 1.
  - At posedge: dmem_req = 1, dmem_we = mem_write, dmem_addr = alu_res, dmem_wdata = wdata; counter = 0; go to WAIT.
  - MEM/WB captures a bubble: wb_reg_write = 0.
- WAIT:
  - dmem_req/addr/wdata/we stay stable.
  - stall = ~dmem_ack. Upstream registers therefore hold the same instruction until the ack cycle.
- WAIT, dmem_ack = 1 at posedge:
  - dmem_req = 0.
  - Load wb_* from the inputs. wb_rdata = dmem_rdata for a load, 0 for a store.
  - Go to IDLE. Upstream advances at the same edge.
- WAIT, dmem_ack = 0:
  - Counter increments each cycle.
  - When counter reaches MAX_WAIT - 1 and dmem_ack = 0: at posedge, dmem_req = 0, timeout_err = 1 for one cycle, wb_reg_write = 0 (bubble); go to IDLE with stall released.
- Ack and timeout in the same cycle: ack wins and no error is raised.
- dmem_ack while in IDLE (late or spurious) is ignored.
- misalign_err and timeout_err are 0 in every cycle other than their one-cycle pulse.
- Minimum load/store occupancy is 2 cycles (IDLE + 1 WAIT cycle). Maximum is MAX_WAIT + 1 cycles.

Test Plan:
- Reset asserted asynchronously mid-cycle during WAIT -> dmem_req, stall and all wb_* read 0 before the next edge; state = IDLE after reset release.
- ALU op: reg_write = 1, alu_res = 0x00000010, dst = 5, mem_op = 0 -> one cycle later wb_alu_res = 0x10, wb_dst = 5, wb_reg_write = 1, stall stays 0.
- Load at alu_res = 0x100, ack returned on the 3rd WAIT cycle with rdata = 0xDEADBEEF -> dmem_req = 1 and dmem_addr = 0x100 for 3 cycles; stall high for 3 cycles; then wb_rdata = 0xDEADBEEF, wb_reg_write = 1; no duplicate request.
- Store at 0x104 with wdata = 0x12345678, ack on the first WAIT cycle -> dmem_we = 1, dmem_wdata = 0x12345678 for 1 cycle; stall high for 1 cycle; wb_rdata = 0.
- Load at 0x102 -> no dmem_req; misalign_err pulses once; wb_reg_write = 0; stall = 0.
- MAX_WAIT = 4, load with no ack -> dmem_req high for 4 cycles, then low; timeout_err pulses once; wb_reg_write = 0; stall released; an ack arriving later in IDLE produces no effect.

Source files
------------

// File: rtl/mem_stage_access.sv
// -----------------------------------------------------------------------------
// mem_stage_access
//
// MEM pipeline stage. Consumes the EX/MEM register (datapath and control),
// turns a registered load/store into a req/ack transaction on the data-memory
// port, stalls the front of the pipeline while an access is outstanding, and
// drives the MEM/WB register for write-back.
//
// Parameters
//   MAX_WAIT      WAIT-state cycles without dmem_ack before the access is
//                 aborted (legal range 1..255).
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-low reset
//   pc_4, alu_res, wdata, dst
//                 EX/MEM datapath fields (alu_res is the byte address)
//   mem_read, mem_write, mem_to_reg, reg_write
//                 EX/MEM control fields
//   dmem_req/we/addr/wdata
//                 registered memory request (we: 1 = store, 0 = load)
//   dmem_ack, dmem_rdata
//                 memory completion and load data
//   stall         combinational; freezes PC, IF/ID, ID/EX and EX/MEM
//   wb_*          registered MEM/WB fields
//   misalign_err, timeout_err
//                 registered one-cycle error pulses
// -----------------------------------------------------------------------------
module mem_stage_access #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_4,
  input  logic [31:0] alu_res,
  input  logic [31:0] wdata,
  input  logic [4:0]  dst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_to_reg,
  input  logic        reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] wb_pc_4,
  output logic [31:0] wb_alu_res,
  output logic [31:0] wb_rdata,
  output logic [4:0]  wb_dst,
  output logic [1:0]  wb_mem_to_reg,
  output logic        wb_reg_write,
  output logic        misalign_err,
  output logic        timeout_err
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Counter value seen in the last WAIT cycle before the access is aborted.
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wb_pc_4_q, wb_pc_4_d;
  logic [31:0] wb_alu_res_q, wb_alu_res_d;
  logic [31:0] wb_rdata_q, wb_rdata_d;
  logic [4:0]  wb_dst_q, wb_dst_d;
  logic [1:0]  wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        misalign_q, misalign_d;
  logic        timeout_q, timeout_d;

  logic        mem_op;
  logic        aligned;
  logic        timeout_hit;
  logic        stall_c;
  logic        load_wb;
  logic        bubble;
  logic [31:0] rdata_sel;

  assign mem_op      = mem_read | mem_write;
  assign aligned     = (alu_res[1:0] == 2'b00);
  assign timeout_hit = (cnt_q == LAST_WAIT);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    req_d           = req_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wb_pc_4_d       = wb_pc_4_q;
    wb_alu_res_d    = wb_alu_res_q;
    wb_rdata_d      = wb_rdata_q;
    wb_dst_d        = wb_dst_q;
    wb_mem_to_reg_d = wb_mem_to_reg_q;
    wb_reg_write_d  = wb_reg_write_q;
    misalign_d      = 1'b0;
    timeout_d       = 1'b0;
    stall_c         = 1'b0;
    load_wb         = 1'b0;
    bubble          = 1'b0;
    rdata_sel       = 32'h0;

    case (state_q)
      IDLE: begin
        // A late or spurious dmem_ack is deliberately not looked at here.
        if (!mem_op) begin
          load_wb = 1'b1;
        end else if (!aligned) begin
          // Misaligned access is dropped without touching the memory port.
          load_wb    = 1'b1;
          bubble     = 1'b1;
          misalign_d = 1'b1;
        end else begin
          // Store wins when both mem_read and mem_write are set.
          stall_c = 1'b1;
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = {alu_res[31:2], 2'b00};
          wdata_d = wdata;
          cnt_d   = 8'd0;
          bubble  = 1'b1;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (dmem_ack) begin
          // Ack beats a coincident timeout; upstream advances at this edge.
          req_d     = 1'b0;
          load_wb   = 1'b1;
          rdata_sel = we_q ? 32'h0 : dmem_rdata;
          state_d   = IDLE;
        end else if (timeout_hit) begin
          // Stall is released in the abort cycle itself so the aborted
          // instruction leaves EX/MEM and is not reissued from IDLE.
          req_d     = 1'b0;
          timeout_d = 1'b1;
          bubble    = 1'b1;
          state_d   = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (load_wb) begin
      wb_pc_4_d       = pc_4;
      wb_alu_res_d    = alu_res;
      wb_rdata_d      = rdata_sel;
      wb_dst_d        = dst;
      wb_mem_to_reg_d = mem_to_reg;
      wb_reg_write_d  = reg_write;
    end
    if (bubble) begin
      wb_reg_write_d = 1'b0;
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= 8'd0;
      req_q           <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= 32'h0;
      wdata_q         <= 32'h0;
      wb_pc_4_q       <= 32'h0;
      wb_alu_res_q    <= 32'h0;
      wb_rdata_q      <= 32'h0;
      wb_dst_q        <= 5'd0;
      wb_mem_to_reg_q <= 2'd0;
      wb_reg_write_q  <= 1'b0;
      misalign_q      <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      req_q           <= req_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      wb_pc_4_q       <= wb_pc_4_d;
      wb_alu_res_q    <= wb_alu_res_d;
      wb_rdata_q      <= wb_rdata_d;
      wb_dst_q        <= wb_dst_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_reg_write_q  <= wb_reg_write_d;
      misalign_q      <= misalign_d;
      timeout_q       <= timeout_d;
    end
  end

  // stall is combinational from the EX/MEM inputs, so it is gated by reset
  // to read 0 while reset is held regardless of what upstream presents.
  assign stall         = rst & stall_c;
  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign wb_pc_4       = wb_pc_4_q;
  assign wb_alu_res    = wb_alu_res_q;
  assign wb_rdata      = wb_rdata_q;
  assign wb_dst        = wb_dst_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign misalign_err  = misalign_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_access
//
// Drives mem_stage_access with directed and random EX/MEM instructions and a
// random memory responder. A transaction-level model tracks whether an access
// is outstanding and how many wait cycles it has used, and predicts every
// output each cycle.
// -----------------------------------------------------------------------------
module tb_mem_stage_access;

  localparam int unsigned MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_4, alu_res, wdata;
  logic [4:0]  dst;
  logic        mem_read, mem_write;
  logic [1:0]  mem_to_reg;
  logic        reg_write;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [31:0] wb_pc_4, wb_alu_res, wb_rdata;
  logic [4:0]  wb_dst;
  logic [1:0]  wb_mem_to_reg;
  logic        wb_reg_write, misalign_err, timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: is an access outstanding, and how many wait cycles it used.
  bit          m_busy;
  int          m_waited;
  logic        e_req, e_we, e_wb_rw, e_mis, e_to;
  logic [31:0] e_addr, e_wdata, e_wb_pc, e_wb_alu, e_wb_rd;
  logic [4:0]  e_wb_dst;
  logic [1:0]  e_wb_m2r;

  bit last_stall;
  int stall_hi, req_hi;

  always #5 clk = ~clk;

  mem_stage_access #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_4         (pc_4),
    .alu_res      (alu_res),
    .wdata        (wdata),
    .dst          (dst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .stall        (stall),
    .wb_pc_4      (wb_pc_4),
    .wb_alu_res   (wb_alu_res),
    .wb_rdata     (wb_rdata),
    .wb_dst       (wb_dst),
    .wb_mem_to_reg(wb_mem_to_reg),
    .wb_reg_write (wb_reg_write),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive(input logic [31:0] p4, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] d, input logic mr, input logic mw,
                       input logic [1:0] m2r, input logic rw);
    pc_4 = p4; alu_res = alu; wdata = wd; dst = d;
    mem_read = mr; mem_write = mw; mem_to_reg = m2r; reg_write = rw;
  endtask

  task automatic nop();
    drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic model_reset();
    m_busy = 0; m_waited = 0;
    e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
    e_wb_pc = 0; e_wb_alu = 0; e_wb_rd = 0; e_wb_dst = 0; e_wb_m2r = 0;
    e_wb_rw = 0; e_mis = 0; e_to = 0;
  endtask

  function automatic bit model_stall();
    bit is_mem, ok;
    is_mem = mem_read | mem_write;
    ok     = (alu_res[1:0] == 2'b00);
    if (!rst) return 1'b0;
    if (!m_busy) return is_mem && ok;
    // The current cycle is wait cycle number m_waited+1 of at most MAX_WAIT.
    return !dmem_ack && (m_waited + 1 < int'(MAX_WAIT));
  endfunction

  task automatic retire(input logic [31:0] rd);
    e_wb_pc = pc_4; e_wb_alu = alu_res; e_wb_rd = rd; e_wb_dst = dst;
    e_wb_m2r = mem_to_reg; e_wb_rw = reg_write;
  endtask

  // Advance the model by one clock edge using the inputs present now.
  task automatic model_step();
    bit is_mem, ok;
    is_mem = mem_read | mem_write;
    ok     = (alu_res[1:0] == 2'b00);
    e_mis = 0; e_to = 0;
    if (!m_busy) begin
      if (is_mem && ok) begin
        m_busy = 1; m_waited = 0;
        e_req = 1; e_we = mem_write; e_addr = alu_res; e_wdata = wdata; e_wb_rw = 0;
      end else begin
        retire(32'h0);
        if (is_mem) begin e_wb_rw = 0; e_mis = 1; end
      end
    end else begin
      m_waited++;
      if (dmem_ack) begin
        retire(e_we ? 32'h0 : dmem_rdata);
        e_req = 0; m_busy = 0;
      end else if (m_waited == int'(MAX_WAIT)) begin
        e_req = 0; e_to = 1; e_wb_rw = 0; m_busy = 0;
      end
    end
  endtask

  task automatic check_outputs(input bit exp_stall);
    check("stall",         32'(stall),         32'(exp_stall));
    check("dmem_req",      32'(dmem_req),      32'(e_req));
    check("dmem_we",       32'(dmem_we),       32'(e_we));
    check("dmem_addr",     dmem_addr,          e_addr);
    check("dmem_wdata",    dmem_wdata,         e_wdata);
    check("wb_pc_4",       wb_pc_4,            e_wb_pc);
    check("wb_alu_res",    wb_alu_res,         e_wb_alu);
    check("wb_rdata",      wb_rdata,           e_wb_rd);
    check("wb_dst",        32'(wb_dst),        32'(e_wb_dst));
    check("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(e_wb_m2r));
    check("wb_reg_write",  32'(wb_reg_write),  32'(e_wb_rw));
    check("misalign_err",  32'(misalign_err),  32'(e_mis));
    check("timeout_err",   32'(timeout_err),   32'(e_to));
  endtask

  // One clock: compare at the falling edge, advance the model, return just
  // after the rising edge so the caller can change inputs.
  task automatic step();
    @(negedge clk);
    last_stall = model_stall();
    if (stall === 1'b1) stall_hi++;
    if (dmem_req === 1'b1) req_hi++;
    check_outputs(last_stall);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    nop();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    model_reset();
    #12;
    check_outputs(1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Plain ALU op: one-cycle latency, no stall.
    drive(32'h44, 32'h10, 32'h0, 5'd5, 1'b0, 1'b0, 2'd0, 1'b1);
    step();
    check("alu wb_alu_res", wb_alu_res, 32'h10);
    check("alu wb_dst", 32'(wb_dst), 32'd5);
    check("alu wb_reg_write", 32'(wb_reg_write), 32'd1);

    // Load at 0x100, ack on the third wait cycle.
    stall_hi = 0; req_hi = 0;
    drive(32'h48, 32'h100, 32'h0, 5'd7, 1'b1, 1'b0, 2'd1, 1'b1);
    step(); step(); step();
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    step();
    dmem_ack = 1'b0; nop();
    check("load stall cycles", 32'(stall_hi), 32'd3);
    check("load req cycles", 32'(req_hi), 32'd3);
    check("load wb_rdata", wb_rdata, 32'hDEADBEEF);
    check("load wb_reg_write", 32'(wb_reg_write), 32'd1);
    step();
    check("load no dup req", 32'(dmem_req), 32'd0);

    // Store at 0x104, ack on the first wait cycle.
    stall_hi = 0; req_hi = 0;
    drive(32'h4C, 32'h104, 32'h12345678, 5'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    step();
    check("store dmem_we", 32'(dmem_we), 32'd1);
    check("store dmem_wdata", dmem_wdata, 32'h12345678);
    dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA;
    step();
    dmem_ack = 1'b0; nop();
    check("store stall cycles", 32'(stall_hi), 32'd1);
    check("store wb_rdata", wb_rdata, 32'h0);

    // Misaligned load at 0x102.
    stall_hi = 0; req_hi = 0;
    drive(32'h50, 32'h102, 32'h0, 5'd3, 1'b1, 1'b0, 2'd1, 1'b1);
    step();
    nop();
    check("misalign pulse", 32'(misalign_err), 32'd1);
    check("misalign bubble", 32'(wb_reg_write), 32'd0);
    check("misalign no stall", 32'(stall_hi), 32'd0);
    step();
    check("misalign no req", 32'(req_hi), 32'd0);
    check("misalign one cycle", 32'(misalign_err), 32'd0);

    // Load that never gets an ack: aborted after MAX_WAIT wait cycles.
    stall_hi = 0; req_hi = 0;
    drive(32'h54, 32'h200, 32'h0, 5'd9, 1'b1, 1'b0, 2'd1, 1'b1);
    for (int i = 0; i < 5; i++) step();
    nop();
    check("timeout req cycles", 32'(req_hi), 32'(MAX_WAIT));
    check("timeout pulse", 32'(timeout_err), 32'd1);
    check("timeout bubble", 32'(wb_reg_write), 32'd0);
    check("timeout req low", 32'(dmem_req), 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    step();
    dmem_ack = 1'b0;
    check("late ack wb_rdata", wb_rdata, 32'h0);
    check("timeout one cycle", 32'(timeout_err), 32'd0);

    // Ack in the last wait cycle beats the timeout.
    drive(32'h58, 32'h300, 32'h0, 5'd11, 1'b1, 1'b0, 2'd1, 1'b1);
    for (int i = 0; i < 4; i++) step();
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
    step();
    dmem_ack = 1'b0; nop();
    check("ack vs timeout err", 32'(timeout_err), 32'd0);
    check("ack vs timeout rdata", wb_rdata, 32'h0BADF00D);

    // Asynchronous reset in the middle of a wait.
    drive(32'h5C, 32'h400, 32'h0, 5'd12, 1'b1, 1'b0, 2'd1, 1'b1);
    step(); step();
    #3 rst = 1'b0;
    #1;
    check("rst dmem_req", 32'(dmem_req), 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    check("rst wb_pc_4", wb_pc_4, 32'h0);
    check("rst wb_alu_res", wb_alu_res, 32'h0);
    check("rst wb_dst", 32'(wb_dst), 32'd0);
    check("rst wb_mem_to_reg", 32'(wb_mem_to_reg), 32'd0);
    check("rst wb_reg_write", 32'(wb_reg_write), 32'd0);
    model_reset();
    nop();
    #2 rst = 1'b1;
    step();
    drive(32'h60, 32'h500, 32'h0, 5'd13, 1'b1, 1'b0, 2'd1, 1'b1);
    step();
    check("post-rst new req", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'h13579BDF;
    step();
    dmem_ack = 1'b0; nop();

    // Random instruction stream with a random responder.
    last_stall = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 9) < 7) a[1:0] = 2'b00;
        drive($urandom, a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
              2'($urandom), 1'($urandom));
      end
      dmem_ack   = ($urandom_range(0, 3) == 0);
      dmem_rdata = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
